// File: rtl/imm_const_seq_if.sv
// Handshake/bus bundle between decode, the constant sequencer and the register-file write port.
// master = sequencer side; slave = the decode/arbiter side that drives requests and grants.
interface imm_const_seq_if #(
  parameter int WIDTH = 64,
  parameter int RA_W  = 5
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic [RA_W-1:0]  rd;
  logic             flush;
  logic             wr_gnt;
  logic             wr_en;
  logic [RA_W-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;

  modport master (
    input  start, value, rd, flush, wr_gnt,
    output wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    output start, value, rd, flush, wr_gnt,
    input  wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/imm_const_seq.sv
// Builds a 64-bit constant in a register via MOVZ/MOVK-style writes; IMM_SEQ_SKIP_ZERO_EN skips zero upper halfwords.
// Accept -> NCHUNK writes (one per granted cycle, held while wr_gnt=0) -> one-cycle done; busy stalls the front end.
module imm_const_seq #(
  parameter int WIDTH  = 64,
  parameter int CHUNK  = 16,
  parameter int NCHUNK = 4,
  parameter int RA_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  imm_const_seq_if.master      bus
);

  localparam logic [RA_W-1:0] XZR = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    Z    = 3'd1,
    K1   = 3'd2,
    K2   = 3'd3,
    K3   = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  val_q, val_d;
  logic [RA_W-1:0]   wr_addr_q, wr_addr_d;

  logic              wr_en_c;
  logic [WIDTH-1:0]  wr_data_c;
  logic              busy_c;
  logic              done_c;
  int                cur_idx;
  int                nxt_idx;

  function automatic int state_idx(input state_e s);
    case (s)
      K1:      return 1;
      K2:      return 2;
      K3:      return 3;
      default: return 0;
    endcase
  endfunction

  function automatic state_e idx_state(input int i);
    case (i)
      0:       return Z;
      1:       return K1;
      2:       return K2;
      3:       return K3;
      default: return DONE;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    val_d     = val_q;
    wr_addr_d = wr_addr_q;
    wr_en_c   = 1'b0;
    wr_data_c = '0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    cur_idx   = 0;
    nxt_idx   = NCHUNK;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          val_d = bus.value;
          if (bus.rd == XZR) begin
            state_d = DONE;
          end else begin
            wr_addr_d = bus.rd;
            state_d   = Z;
          end
        end
      end

      Z, K1, K2, K3: begin
        busy_c  = 1'b1;
        wr_en_c = 1'b1;
        cur_idx = state_idx(state_q);
        // Z zero-extends; later steps keep every bit of acc except the chunk being inserted.
        wr_data_c = (state_q == Z) ? '0 : acc_q;
        wr_data_c[cur_idx*CHUNK +: CHUNK] = val_q[cur_idx*CHUNK +: CHUNK];

        nxt_idx = cur_idx + 1;
`ifdef IMM_SEQ_SKIP_ZERO_EN
        nxt_idx = NCHUNK;
        for (int j = NCHUNK - 1; j > 0; j--) begin
          if (j > cur_idx && val_q[j*CHUNK +: CHUNK] != '0) begin
            nxt_idx = j;
          end
        end
`endif
        if (bus.wr_gnt) begin
          acc_d   = wr_data_c;
          state_d = idx_state(nxt_idx);
        end
      end

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A write shown in the flush cycle is still taken by the arbiter if granted.
    if (bus.flush && state_q != IDLE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      val_q     <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      val_q     <= val_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.wr_en   = wr_en_c;
  assign bus.wr_data = wr_data_c;
  assign bus.wr_addr = wr_addr_q;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;

endmodule

// File: tb/tb_imm_const_seq.sv
// Randomised and directed bench for imm_const_seq against a queue-of-expected-writes model.
// Literal tables pin the main sequence, grant stalls, XZR, flush, reset and the skip behaviour.
module tb_imm_const_seq;

  logic clk;
  logic reset;

  imm_const_seq_if #(.WIDTH(64), .RA_W(5)) bus ();

  imm_const_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sequence is the list of register values the write port must show, in order.
  logic [63:0] mq[$];
  bit          m_done;
  logic [4:0]  m_addr;
  logic [63:0] mask;

  always @(negedge clk) begin
    if (checking) begin
      chk("wr_en", bus.wr_en, (mq.size() > 0));
      chk("busy",  bus.busy,  (mq.size() > 0));
      chk("done",  bus.done,  (mq.size() == 0) && m_done);
      if (mq.size() > 0) begin
        chk("wr_data", bus.wr_data, mq[0]);
        chk("wr_addr", bus.wr_addr, m_addr);
      end
    end
    if (!reset) begin
      mq.delete();
      m_done = 1'b0;
    end else if (mq.size() > 0) begin
      if (bus.flush) begin
        mq.delete();
      end else if (bus.wr_gnt) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (bus.start && !bus.flush) begin
      if (bus.rd == 5'd31) begin
        m_done = 1'b1;
      end else begin
        m_addr = bus.rd;
        for (int k = 0; k < 4; k++) begin
          mask = (k == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (16 * (k + 1))) - 64'd1);
`ifdef IMM_SEQ_SKIP_ZERO_EN
          if (k == 0 || bus.value[16*k +: 16] != 16'h0)
`endif
          mq.push_back(bus.value & mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] VA = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] VS = 64'h0000_00FF_0000_0001;

  initial begin
    logic [63:0] exp_a [4];
    logic [63:0] rv;
    exp_a[0] = 64'h0000_0000_0000_DEF0;
    exp_a[1] = 64'h0000_0000_9ABC_DEF0;
    exp_a[2] = 64'h0000_5678_9ABC_DEF0;
    exp_a[3] = 64'h1234_5678_9ABC_DEF0;

    reset = 1'b0; bus.start = 1'b0; bus.flush = 1'b0; bus.wr_gnt = 1'b1;
    bus.value = '0; bus.rd = '0;
    repeat (2) tick();
    reset = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    tick();

    // Main sequence, grant tied high.
    bus.value = VA; bus.rd = 5'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("A_wr_en", bus.wr_en, 1);
        chk("A_wr_data", bus.wr_data, exp_a[c-1]);
        chk("A_wr_addr", bus.wr_addr, 3);
      end else begin
        chk("A_done", bus.done, 1);
        chk("A_wr_en_done", bus.wr_en, 0);
      end
      tick();
    end

    // Grant low for three cycles in K1.
    bus.value = VA; bus.rd = 5'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.wr_gnt = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        chk("B_hold_en", bus.wr_en, 1);
        chk("B_hold_data", bus.wr_data, 64'h0000_0000_9ABC_DEF0);
      end
      chk("B_done", bus.done, (c == 8));
      tick();
      if (c == 4) bus.wr_gnt = 1'b1;
    end

    // XZR destination: no write, done right after accept.
    bus.value = 64'hFFFF_FFFF_FFFF_FFFF; bus.rd = 5'd31; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("C_done", bus.done, 1);
    chk("C_wr_en", bus.wr_en, 0);
    tick();
    @(negedge clk);
    chk("C_idle", bus.done, 0);
    tick();

    // Flush in K2 with a competing start.
    bus.value = VA; bus.rd = 5'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1; bus.start = 1'b1; bus.value = 64'h5555; bus.rd = 5'd9;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("D_busy", bus.busy, 0);
    chk("D_done", bus.done, 0);
    chk("D_wr_en", bus.wr_en, 0);
    tick();
    @(negedge clk);
    chk("D_no_accept", bus.busy, 0);
    tick();

    // Reset in K2, start held during reset.
    bus.value = VA; bus.rd = 5'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b0; bus.start = 1'b1;
    tick();
    @(negedge clk);
    chk("E_wr_en", bus.wr_en, 0);
    chk("E_busy", bus.busy, 0);
    chk("E_done", bus.done, 0);
    chk("E_wr_addr", bus.wr_addr, 0);
    tick();
    @(negedge clk);
    chk("E_busy_held", bus.busy, 0);
    tick();
    reset = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("E_after", bus.busy, 0);
    tick();

    // Sparse value: skip behaviour depends on the build.
    bus.value = VS; bus.rd = 5'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
`ifdef IMM_SEQ_SKIP_ZERO_EN
    @(negedge clk); chk("S_w1", bus.wr_data, 64'h1); tick();
    @(negedge clk); chk("S_w2", bus.wr_data, VS); tick();
    @(negedge clk); chk("S_done", bus.done, 1); tick();
`else
    @(negedge clk); chk("S_w1", bus.wr_data, 64'h1); tick();
    @(negedge clk); chk("S_w2", bus.wr_data, 64'h1); tick();
    @(negedge clk); chk("S_w3", bus.wr_data, VS); tick();
    @(negedge clk); chk("S_w4", bus.wr_data, VS); tick();
    @(negedge clk); chk("S_done", bus.done, 1); tick();
`endif
    tick();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rv = {$urandom, $urandom};
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) rv[16*k +: 16] = 16'h0;
      bus.value  = rv;
      bus.rd     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.flush  = ($urandom_range(0, 24) == 0);
      bus.wr_gnt = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 99) != 0);
      tick();
    end
    reset = 1'b1; bus.start = 1'b0; bus.flush = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
